// File: rtl/sysid_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sysid_pkg
//  Description : Shared definitions for the sysid checker: controller state
//                enumeration, sysid slave word addresses and the default
//                expected ID / timestamp words.
//  Revision    : 1.0  initial release
// ============================================================================
package sysid_pkg;

    // Controller states of the check sequence
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RD_ID = 2'd1,
        ST_RD_TS = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Word addresses inside the sysid slave
    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    // Default contents of a freshly generated sysid block
    localparam logic [31:0] SYSID_DEFAULT_ID = 32'd0;
    localparam logic [31:0] SYSID_DEFAULT_TS = 32'd1392314294;

endpackage : sysid_pkg
`default_nettype wire

// File: rtl/sysid_checker.sv
`default_nettype none
// ============================================================================
//  Module      : sysid_checker
//  Description : Reads the system ID word (address 0) and the timestamp word
//                (address 1) from a sysid slave over Avalon-MM, compares them
//                against the expected values and reports the result. Each
//                read is guarded by a stall-cycle timeout.
//
//  Ports
//    clock           : sole clock, rising edge
//    reset_n         : asynchronous active-low reset
//    start           : launch a check sequence (honoured in IDLE and DONE)
//    avm_address     : slave word address, 0 = ID, 1 = timestamp
//    avm_read        : Avalon-MM read strobe
//    avm_readdata    : slave read data
//    avm_waitrequest : slave stall
//    busy            : a read is in progress
//    done            : sequence finished, held until the next launch
//    id_ok / ts_ok   : captured word matched its expected value
//    timeout         : a read stalled for TIMEOUT_CYCLES cycles
//    id_value        : last captured ID word
//    ts_value        : last captured timestamp word
//
//  Revision    : 1.0  initial release
// ============================================================================
module sysid_checker
    import sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = SYSID_DEFAULT_ID,
    parameter logic [31:0] EXPECTED_TS    = SYSID_DEFAULT_TS,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned AUTO_START     = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    localparam logic [15:0] c_timeout    = 16'(TIMEOUT_CYCLES);
    localparam logic        c_auto_start = (AUTO_START != 0);

    state_t      r_state;
    logic [15:0] r_wait_cnt;
    logic        r_launch;

    logic [15:0] w_wait_next;
    logic        w_timed_out;

    // The current stalled cycle is the last one tolerated when the count,
    // including this cycle, reaches the limit.
    assign w_wait_next = r_wait_cnt + 16'd1;
    assign w_timed_out = (w_wait_next == c_timeout);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_wait_cnt  <= 16'd0;
            // One-shot launch flag, armed by reset when auto start is enabled
            r_launch    <= c_auto_start;
            avm_read    <= 1'b0;
            avm_address <= SYSID_ADDR_ID;
            busy        <= 1'b0;
            done        <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout     <= 1'b0;
            id_value    <= 32'd0;
            ts_value    <= 32'd0;
        end else begin
            r_launch <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start || (r_launch && (r_state == ST_IDLE))) begin
                        r_state     <= ST_RD_ID;
                        r_wait_cnt  <= 16'd0;
                        avm_read    <= 1'b1;
                        avm_address <= SYSID_ADDR_ID;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        id_ok       <= 1'b0;
                        ts_ok       <= 1'b0;
                        timeout     <= 1'b0;
                    end
                end

                ST_RD_ID: begin
                    if (!avm_waitrequest) begin
                        id_value    <= avm_readdata;
                        id_ok       <= (avm_readdata == EXPECTED_ID);
                        r_state     <= ST_RD_TS;
                        r_wait_cnt  <= 16'd0;
                        avm_address <= SYSID_ADDR_TS;
                    end else if (w_timed_out) begin
                        // Abandon the whole sequence; timestamp is never read
                        timeout     <= 1'b1;
                        r_state     <= ST_DONE;
                        avm_read    <= 1'b0;
                        avm_address <= SYSID_ADDR_ID;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                    end else begin
                        r_wait_cnt  <= w_wait_next;
                    end
                end

                ST_RD_TS: begin
                    if (!avm_waitrequest) begin
                        ts_value    <= avm_readdata;
                        ts_ok       <= (avm_readdata == EXPECTED_TS);
                        r_state     <= ST_DONE;
                        avm_read    <= 1'b0;
                        avm_address <= SYSID_ADDR_ID;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                    end else if (w_timed_out) begin
                        timeout     <= 1'b1;
                        r_state     <= ST_DONE;
                        avm_read    <= 1'b0;
                        avm_address <= SYSID_ADDR_ID;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                    end else begin
                        r_wait_cnt  <= w_wait_next;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : sysid_checker
`default_nettype wire

// File: tb/tb_sysid_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sysid_checker
//  Description : Self-checking bench for sysid_checker. A behavioural slave
//                stalls each read by a planned number of cycles; expected
//                sequence results come from a reference model and are queued
//                at launch, and a monitor compares them when done rises.
//                A second instance with auto start disabled exercises the
//                asynchronous reset in the middle of a read.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sysid_checker;

    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1392314294;
    localparam int          TMO    = 4;
    localparam logic [31:0] ID2    = 32'h0000_1234;

    typedef struct {
        logic        id_ok;
        logic        ts_ok;
        logic        tmo;
        logic        ts_seen;
        logic [31:0] idv;
        logic [31:0] tsv;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic        busy, done, id_ok, ts_ok, timeout;
    logic [31:0] id_value, ts_value;

    logic        rst2_n;
    logic        start2;
    logic        addr2, rd2, wr2;
    logic [31:0] rdata2;
    logic        busy2, done2, idok2, tsok2, tmo2;
    logic [31:0] idv2, tsv2;

    int          total = 0;
    int          bad   = 0;

    exp_t        exp_q[$];
    logic [31:0] mdl_idv = 32'd0;
    logic [31:0] mdl_tsv = 32'd0;

    int          plan_stall [2];
    logic [31:0] plan_data  [2];

    int          s_k = 0;
    logic        s_prev_read  = 1'b0;
    logic        s_prev_addr  = 1'b0;
    logic        s_prev_stall = 1'b0;
    logic        seq_ts_seen  = 1'b0;

    logic        m_prev_done = 1'b0;
    int          m_busy_cyc  = 0;

    always #5 clk = ~clk;

    sysid_checker #(
        .EXPECTED_ID   (EXP_ID),
        .EXPECTED_TS   (EXP_TS),
        .TIMEOUT_CYCLES(TMO),
        .AUTO_START    (1)
    ) u_dut (
        .clock          (clk),
        .reset_n        (rst_n),
        .start          (start),
        .avm_address    (avm_address),
        .avm_read       (avm_read),
        .avm_readdata   (avm_readdata),
        .avm_waitrequest(avm_waitrequest),
        .busy           (busy),
        .done           (done),
        .id_ok          (id_ok),
        .ts_ok          (ts_ok),
        .timeout        (timeout),
        .id_value       (id_value),
        .ts_value       (ts_value)
    );

    assign rdata2 = addr2 ? EXP_TS : ID2;

    sysid_checker #(
        .AUTO_START(0)
    ) u_dut2 (
        .clock          (clk),
        .reset_n        (rst2_n),
        .start          (start2),
        .avm_address    (addr2),
        .avm_read       (rd2),
        .avm_readdata   (rdata2),
        .avm_waitrequest(wr2),
        .busy           (busy2),
        .done           (done2),
        .id_ok          (idok2),
        .ts_ok          (tsok2),
        .timeout        (tmo2),
        .id_value       (idv2),
        .ts_value       (tsv2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each read lasts one cycle plus its stalls; a read that
    // stalls TMO cycles ends the sequence with timeout and no capture.
    task automatic push_exp(input logic [31:0] did, input logic [31:0] dts,
                            input int sid, input int sts);
        exp_t e;
        e.id_ok = 1'b0; e.ts_ok = 1'b0; e.tmo = 1'b0; e.ts_seen = 1'b0;
        if (sid >= TMO) begin
            e.tmo = 1'b1;
            e.lat = TMO;
        end else begin
            mdl_idv   = did;
            e.id_ok   = (did == EXP_ID);
            e.ts_seen = 1'b1;
            e.lat     = sid + 1;
            if (sts >= TMO) begin
                e.tmo = 1'b1;
                e.lat = e.lat + TMO;
            end else begin
                mdl_tsv = dts;
                e.ts_ok = (dts == EXP_TS);
                e.lat   = e.lat + sts + 1;
            end
        end
        e.idv = mdl_idv;
        e.tsv = mdl_tsv;
        exp_q.push_back(e);
    endtask

    task automatic set_plan(input logic [31:0] did, input logic [31:0] dts,
                            input int sid, input int sts);
        plan_data[0]  = did;
        plan_data[1]  = dts;
        plan_stall[0] = sid;
        plan_stall[1] = sts;
        push_exp(did, dts, sid, sts);
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 200 && !done; i++) @(negedge clk);
        if (!done) begin
            chk({name, "_done_wait"}, 32'(done), 32'd1);
        end
    endtask

    // Called at a negedge while the DUT sits in DONE.
    task automatic run_seq(input logic [31:0] did, input logic [31:0] dts,
                           input int sid, input int sts, input bit extra);
        set_plan(did, dts, sid, sts);
        start = 1'b1;
        @(negedge clk);
        start = extra;   // sampled while reading: must be ignored
        chk("launch_busy", 32'(busy), 32'd1);
        chk("launch_done", 32'(done), 32'd0);
        @(negedge clk);
        start = 1'b0;
        wait_done("seq");
        repeat ($urandom_range(1, 3)) @(negedge clk);
    endtask

    // Behavioural slave plus stall-stability checks
    always @(negedge clk) begin
        if (!rst_n) begin
            s_k = 0; s_prev_read = 1'b0; s_prev_addr = 1'b0; s_prev_stall = 1'b0;
            avm_waitrequest = 1'b0;
            avm_readdata    = 32'd0;
        end else begin
            if (s_prev_stall && (s_k + 1 < TMO)) begin
                chk("stall_read", 32'(avm_read), 32'd1);
                chk("stall_addr", 32'(avm_address), 32'(s_prev_addr));
            end
            if (!avm_read)                                       s_k = 0;
            else if (!s_prev_read || avm_address != s_prev_addr) s_k = 0;
            else                                                 s_k = s_k + 1;
            if (avm_read && avm_address) seq_ts_seen = 1'b1;
            if (avm_read) begin
                avm_waitrequest = (s_k < plan_stall[avm_address]);
                avm_readdata    = avm_waitrequest ? $urandom : plan_data[avm_address];
            end else begin
                avm_waitrequest = 1'($urandom);
                avm_readdata    = $urandom;
            end
            s_prev_read  = avm_read;
            s_prev_addr  = avm_address;
            s_prev_stall = avm_read && avm_waitrequest;
        end
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            m_prev_done = 1'b0;
            m_busy_cyc  = 0;
        end else begin
            if (busy) m_busy_cyc++;
            if (done && !m_prev_done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("id_ok",    32'(id_ok),       32'(e.id_ok));
                    chk("ts_ok",    32'(ts_ok),       32'(e.ts_ok));
                    chk("timeout",  32'(timeout),     32'(e.tmo));
                    chk("id_value", id_value,         e.idv);
                    chk("ts_value", ts_value,         e.tsv);
                    chk("latency",  32'(m_busy_cyc),  32'(e.lat));
                    chk("ts_seen",  32'(seq_ts_seen), 32'(e.ts_seen));
                    chk("busy_off", 32'(busy),        32'd0);
                    chk("read_off", 32'(avm_read),    32'd0);
                end
                m_busy_cyc  = 0;
                seq_ts_seen = 1'b0;
            end
            m_prev_done = done;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no_finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rid, rts;
        int          sid, sts, r;

        rst_n = 1'b0; rst2_n = 1'b0; start = 1'b0; start2 = 1'b0; wr2 = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_read",  32'(avm_read),    32'd0);
        chk("rst_addr",  32'(avm_address), 32'd0);
        chk("rst_busy",  32'(busy),        32'd0);
        chk("rst_done",  32'(done),        32'd0);
        chk("rst_flags", {29'd0, id_ok, ts_ok, timeout}, 32'd0);
        chk("rst_idv",   id_value, 32'd0);
        chk("rst_tsv",   ts_value, 32'd0);

        // Auto-started sequence with a matching zero-wait slave
        set_plan(EXP_ID, EXP_TS, 0, 0);
        rst_n  = 1'b1;
        rst2_n = 1'b1;
        wait_done("auto");
        repeat (2) @(negedge clk);

        run_seq(32'h0000_0005, EXP_TS, 0, 0, 1'b0);     // ID mismatch
        run_seq(EXP_ID, EXP_TS, 3, 3, 1'b1);            // three stalls each
        run_seq(32'hDEAD_BEEF, 32'h1, 1000, 0, 1'b0);   // ID read stuck
        run_seq(EXP_ID, EXP_TS, 0, 1000, 1'b0);         // TS read stuck
        run_seq(EXP_ID, 32'h7, 3, TMO, 1'b0);           // limit on TS read
        run_seq(32'h9, EXP_TS, TMO, 3, 1'b1);           // limit on ID read

        for (int n = 0; n < 30; n++) begin
            rid = ($urandom % 2 == 0) ? EXP_ID : $urandom;
            rts = ($urandom % 2 == 0) ? EXP_TS : $urandom;
            r   = $urandom % 10;
            sid = (r < 6) ? $urandom_range(0, 2) : (r < 8) ? 3 : (r < 9) ? 4 : 6;
            r   = $urandom % 10;
            sts = (r < 6) ? $urandom_range(0, 2) : (r < 8) ? 3 : (r < 9) ? 4 : 6;
            run_seq(rid, rts, sid, sts, 1'($urandom));
        end
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        // Second instance: no auto start, then reset during a TS stall
        chk("ns_idle_read", 32'(rd2),   32'd0);
        chk("ns_idle_busy", 32'(busy2), 32'd0);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        for (int i = 0; i < 20 && !done2; i++) @(negedge clk);
        chk("ns_done",  32'(done2), 32'd1);
        chk("ns_idv",   idv2, ID2);
        chk("ns_tsv",   tsv2, EXP_TS);
        chk("ns_flags", {30'd0, idok2, tsok2}, 32'd1);

        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        for (int i = 0; i < 20 && !(rd2 && addr2); i++) @(negedge clk);
        chk("ns_in_ts", {30'd0, rd2, addr2}, 32'd3);
        wr2 = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst2_n = 1'b0;
        #1;
        chk("mr_read",  32'(rd2),   32'd0);
        chk("mr_addr",  32'(addr2), 32'd0);
        chk("mr_busy",  32'(busy2), 32'd0);
        chk("mr_done",  32'(done2), 32'd0);
        chk("mr_flags", {29'd0, idok2, tsok2, tmo2}, 32'd0);
        chk("mr_idv",   idv2, 32'd0);
        chk("mr_tsv",   tsv2, 32'd0);
        repeat (2) @(negedge clk);
        wr2    = 1'b0;
        rst2_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_read", 32'(rd2), 32'd0);
        end
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        for (int i = 0; i < 20 && !done2; i++) @(negedge clk);
        chk("again_done", 32'(done2), 32'd1);
        chk("again_idv",  idv2, ID2);
        chk("again_tsv",  tsv2, EXP_TS);
        chk("again_tmo",  32'(tmo2), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sysid_checker
`default_nettype wire
